// File: rtl/mac_ifm_sequencer.sv
// Feeds buffered 4-bit operand pairs to the MAC in fixed-length bursts and
// returns the MAC's 10-bit sum to the host over a valid/ready port.
module mac_ifm_sequencer #(
   parameter int PAIRS     = 4,
   parameter int BUF_DEPTH = 16,
   parameter int TIMEOUT   = 64
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         wr_en_i,
   input  logic [3:0]                   wr_a_i,
   input  logic [3:0]                   wr_b_i,
   output logic                         buf_full_o,
   output logic [$clog2(BUF_DEPTH):0]   buf_count_o,
   output logic                         in_valid_o,
   output logic [3:0]                   in1_IFM_o,
   output logic [3:0]                   in2_IFM_o,
   input  logic                         out_valid_i,
   input  logic [9:0]                   out_i,
   output logic                         res_valid_o,
   output logic [9:0]                   res_data_o,
   input  logic                         res_ready_i,
   output logic                         err_timeout_o,
   output logic                         err_unexp_o,
   output logic [7:0]                   jobs_done_o
);

   localparam int PTR_W  = $clog2(BUF_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int BEAT_W = (PAIRS > 1) ? $clog2(PAIRS) : 1;
   localparam int WAIT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HOLD
   } state_e;

   state_e              state_q, state_d;
   logic [BEAT_W-1:0]   beat_q, beat_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [7:0]          mem_q [BUF_DEPTH];
   logic                in_valid_q, in_valid_d;
   logic [3:0]          in1_q, in1_d;
   logic [3:0]          in2_q, in2_d;
   logic [9:0]          res_data_q, res_data_d;
   logic                err_timeout_q, err_timeout_d;
   logic                err_unexp_q, err_unexp_d;
   logic [7:0]          jobs_q, jobs_d;

   logic                buf_full;
   logic                pop;
   logic                push;
   logic [7:0]          rd_data;

   assign buf_full = (count_q == CNT_W'(BUF_DEPTH));
   assign rd_data  = mem_q[rd_ptr_q];

   always_comb begin
      // NOTE: every variable gets a default before the case so no path infers a latch.
      state_d       = state_q;
      beat_d        = beat_q;
      wait_d        = wait_q;
      res_data_d    = res_data_q;
      err_timeout_d = err_timeout_q;
      err_unexp_d   = err_unexp_q | (out_valid_i && (state_q != S_WAIT));
      jobs_d        = jobs_q;
      pop           = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (count_q >= CNT_W'(PAIRS)) begin
               state_d = S_ISSUE;
               beat_d  = '0;
               pop     = 1'b1;
            end
         end
         S_ISSUE: begin
            // beat_q names the beat currently on the MAC inputs
            if (beat_q == BEAT_W'(PAIRS - 1)) begin
               state_d = S_WAIT;
               wait_d  = '0;
            end else begin
               beat_d = beat_q + 1'b1;
               pop    = 1'b1;
            end
         end
         S_WAIT: begin
            if (out_valid_i) begin
               res_data_d = out_i;
               state_d    = S_HOLD;
            end else if (wait_q == WAIT_W'(TIMEOUT)) begin
               err_timeout_d = 1'b1;
               state_d       = S_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (res_ready_i) begin
               jobs_d  = jobs_q + 8'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A pop frees a slot in the same cycle, so a full buffer still accepts.
      push = wr_en_i && (!buf_full || pop);

      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      in_valid_d = pop;
      in1_d      = pop ? rd_data[7:4] : 4'd0;
      in2_d      = pop ? rd_data[3:0] : 4'd0;
   end

   // NOTE: buffer storage is not reset; emptying it only needs the pointers and count cleared.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {wr_a_i, wr_b_i};
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= S_IDLE;
         beat_q        <= '0;
         wait_q        <= '0;
         count_q       <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         in_valid_q    <= 1'b0;
         in1_q         <= 4'd0;
         in2_q         <= 4'd0;
         res_data_q    <= 10'd0;
         err_timeout_q <= 1'b0;
         err_unexp_q   <= 1'b0;
         jobs_q        <= 8'd0;
      end else begin
         state_q       <= state_d;
         beat_q        <= beat_d;
         wait_q        <= wait_d;
         count_q       <= count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         in_valid_q    <= in_valid_d;
         in1_q         <= in1_d;
         in2_q         <= in2_d;
         res_data_q    <= res_data_d;
         err_timeout_q <= err_timeout_d;
         err_unexp_q   <= err_unexp_d;
         jobs_q        <= jobs_d;
      end
   end

   assign buf_full_o    = buf_full;
   assign buf_count_o   = count_q;
   assign in_valid_o    = in_valid_q;
   assign in1_IFM_o     = in1_q;
   assign in2_IFM_o     = in2_q;
   assign res_valid_o   = (state_q == S_HOLD);
   assign res_data_o    = res_data_q;
   assign err_timeout_o = err_timeout_q;
   assign err_unexp_o   = err_unexp_q;
   assign jobs_done_o   = jobs_q;

endmodule

// File: tb/tb_mac_ifm_sequencer.sv
// Directed bench for mac_ifm_sequencer: a queue-based reference model checked
// every cycle, plus hand-computed expectations at key points of each scenario.
module tb_mac_ifm_sequencer;

   localparam int PAIRS     = 4;
   localparam int BUF_DEPTH = 16;
   localparam int TIMEOUT   = 64;
   localparam int PERIOD    = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic [3:0] wr_a, wr_b;
   logic       buf_full;
   logic [4:0] buf_count;
   logic       in_valid;
   logic [3:0] in1, in2;
   logic       out_valid;
   logic [9:0] out;
   logic       res_valid;
   logic [9:0] res_data;
   logic       res_ready;
   logic       err_timeout, err_unexp;
   logic [7:0] jobs_done;

   always #(PERIOD / 2) clk = ~clk;

   mac_ifm_sequencer #(.PAIRS(PAIRS), .BUF_DEPTH(BUF_DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .wr_en_i      (wr_en),
      .wr_a_i       (wr_a),
      .wr_b_i       (wr_b),
      .buf_full_o   (buf_full),
      .buf_count_o  (buf_count),
      .in_valid_o   (in_valid),
      .in1_IFM_o    (in1),
      .in2_IFM_o    (in2),
      .out_valid_i  (out_valid),
      .out_i        (out),
      .res_valid_o  (res_valid),
      .res_data_o   (res_data),
      .res_ready_i  (res_ready),
      .err_timeout_o(err_timeout),
      .err_unexp_o  (err_unexp),
      .jobs_done_o  (jobs_done)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Reference model: the buffer is a queue, a job is a countdown of beats
   typedef enum int {M_IDLE, M_ISSUE, M_WAIT, M_HOLD} mphase_e;
   mphase_e    m_phase = M_IDLE;
   mphase_e    m_old;
   logic [7:0] m_q[$];
   int         m_beats = 0;
   int         m_wait  = 0;
   logic       e_iv = 0, e_errt = 0, e_erru = 0;
   logic [3:0] e_a = 0, e_b = 0;
   logic [9:0] e_res = 0;
   logic [7:0] e_jobs = 0;

   task automatic model_step();
      logic       pop_now;
      logic [7:0] popped;
      int         size0;
      if (rst) begin
         m_q.delete();
         m_phase = M_IDLE; m_beats = 0; m_wait = 0;
         e_iv = 0; e_a = 0; e_b = 0; e_res = 0; e_errt = 0; e_erru = 0; e_jobs = 0;
         return;
      end
      m_old = m_phase;
      case (m_old)
         M_IDLE:  if (m_q.size() >= PAIRS) begin m_phase = M_ISSUE; m_beats = PAIRS; end
         M_ISSUE: if (m_beats == 0) begin m_phase = M_WAIT; m_wait = 0; end
         M_WAIT: begin
            if (out_valid) begin e_res = out; m_phase = M_HOLD; end
            else if (m_wait == TIMEOUT) begin e_errt = 1; m_phase = M_IDLE; end
            else m_wait++;
         end
         M_HOLD:  if (res_ready) begin e_jobs = e_jobs + 8'd1; m_phase = M_IDLE; end
         default: m_phase = M_IDLE;
      endcase
      if (out_valid && m_old != M_WAIT) e_erru = 1;
      pop_now = (m_phase == M_ISSUE) && (m_beats > 0);
      size0   = m_q.size();
      e_iv = pop_now; e_a = 0; e_b = 0;
      if (pop_now) begin
         popped = m_q.pop_front();
         e_a = popped[7:4];
         e_b = popped[3:0];
         m_beats--;
      end
      if (wr_en && (size0 < BUF_DEPTH || pop_now)) m_q.push_back({wr_a, wr_b});
   endtask

   initial forever @(posedge clk) model_step();

   logic       chk_en = 0;
   logic [7:0] seen[$];

   initial forever @(negedge clk) begin
      if (chk_en) begin
         check("in_valid",    in_valid,    e_iv);
         check("in1_IFM",     in1,         e_a);
         check("in2_IFM",     in2,         e_b);
         check("buf_count",   buf_count,   m_q.size());
         check("buf_full",    buf_full,    m_q.size() == BUF_DEPTH);
         check("res_valid",   res_valid,   m_phase == M_HOLD);
         check("res_data",    res_data,    e_res);
         check("err_timeout", err_timeout, e_errt);
         check("err_unexp",   err_unexp,   e_erru);
         check("jobs_done",   jobs_done,   e_jobs);
         if (in_valid === 1'b1) seen.push_back({in1, in2});
      end
   end

   logic [7:0] stim_q[$];

   task automatic push_all();
      while (stim_q.size() > 0) begin
         @(negedge clk);
         {wr_a, wr_b} = stim_q.pop_front();
         wr_en = 1'b1;
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic wait_iv(input logic lvl, input string name);
      int n = 0;
      while (in_valid !== lvl && n < 300) begin @(negedge clk); n++; end
      check(name, in_valid, lvl);
   endtask

   task automatic wait_res();
      int n = 0;
      while (res_valid !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      check("res_valid rise", res_valid, 1);
   endtask

   // MAC stand-in: strobe `value` lat cycles after the last beat
   task automatic mac_respond(input logic [9:0] value, input int lat);
      wait_iv(1'b1, "burst start");
      wait_iv(1'b0, "burst end");
      repeat (lat - 1) @(negedge clk);
      out = value;
      out_valid = 1'b1;
      @(negedge clk);
      out_valid = 1'b0;
   endtask

   task automatic handshake();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   time t0;

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_a = 0; wr_b = 0;
      out_valid = 1'b0; out = 0; res_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      check("reset buf_count", buf_count, 0);
      check("reset in_valid", in_valid, 0);
      check("reset jobs_done", jobs_done, 0);
      rst = 1'b0;

      // Basic job
      seen.delete();
      stim_q = {8'h12, 8'h34, 8'h56, 8'h78};
      push_all();
      mac_respond(10'd100, 2);
      wait_res();
      check("basic res_data", res_data, 100);
      check("basic beat count", seen.size(), 4);
      for (int i = 0; i < 4 && i < seen.size(); i++)
         check("basic beat order", seen[i], 8'h12 + 8'h22 * i);
      handshake();
      check("basic jobs_done", jobs_done, 1);
      check("basic res_valid low", res_valid, 0);

      // Max value with backpressure and a second job queued
      repeat (8) stim_q.push_back(8'hFF);
      push_all();
      mac_respond(10'd900, 2);
      wait_res();
      for (int i = 0; i < 10; i++) begin
         check("hold res_data", res_data, 900);
         check("hold res_valid", res_valid, 1);
         check("hold no burst", in_valid, 0);
         @(negedge clk);
      end
      check("hold buffered", buf_count, 4);
      handshake();
      check("post-accept res_valid", res_valid, 0);
      check("post-accept idle gap", in_valid, 0);
      @(negedge clk);
      check("next burst start", in_valid, 1);
      mac_respond(10'd900, 3);
      wait_res();
      handshake();
      check("bp jobs_done", jobs_done, 3);

      // Unexpected strobes in IDLE and HOLD
      check("unexp clear", err_unexp, 0);
      out = 10'd999; out_valid = 1'b1;
      @(negedge clk);
      out_valid = 1'b0;
      check("unexp idle flag", err_unexp, 1);
      check("unexp idle res_data", res_data, 900);
      stim_q = {8'h21, 8'h43, 8'h65, 8'h87};
      push_all();
      mac_respond(10'd55, 2);
      wait_res();
      out = 10'd777; out_valid = 1'b1;
      @(negedge clk);
      out_valid = 1'b0;
      check("unexp hold res_data", res_data, 55);
      check("unexp hold res_valid", res_valid, 1);
      handshake();
      check("unexp jobs_done", jobs_done, 4);

      // Strobe on the last allowed WAIT cycle
      stim_q = {8'h9A, 8'hBC, 8'hDE, 8'hF0};
      push_all();
      mac_respond(10'd321, TIMEOUT + 1);
      wait_res();
      check("edge no timeout", err_timeout, 0);
      check("edge res_data", res_data, 321);
      handshake();

      // Silent MAC: fill buffer during WAIT, then timeout
      stim_q = {8'h01, 8'h02, 8'h03, 8'h04};
      push_all();
      wait_iv(1'b1, "silent burst start");
      wait_iv(1'b0, "silent burst end");
      t0 = $time;
      for (int i = 0; i < 16; i++) stim_q.push_back({4'(i), 4'(i)});
      stim_q.push_back(8'hC3);
      push_all();
      check("full count", buf_count, 16);
      check("full flag", buf_full, 1);
      begin
         int n = 0;
         while (err_timeout !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      end
      check("timeout flag", err_timeout, 1);
      check("timeout cycles", int'(($time - t0) / PERIOD), 65);
      seen.delete();
      {wr_a, wr_b} = 8'hEE; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      check("push+pop when full", buf_count, 16);
      check("reissue first beat", in_valid, 1);
      mac_respond(10'd42, 2);
      wait_res();
      check("reissue beat count", seen.size(), 4);
      for (int i = 0; i < 4 && i < seen.size(); i++)
         check("reissue beat order", seen[i], 8'h11 * i);
      handshake();
      check("timeout jobs_done", jobs_done, 6);

      // Reset on beat 2 of the next burst
      wait_iv(1'b1, "reset burst start");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst in_valid", in_valid, 0);
      check("rst buf_count", buf_count, 0);
      check("rst err_timeout", err_timeout, 0);
      check("rst err_unexp", err_unexp, 0);
      check("rst jobs_done", jobs_done, 0);
      check("rst res_valid", res_valid, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
